srambank_param: RTL

Parametrised synchronous SRAM bank: successor to the fixed 256x72 bank. It adds:
- configurable bank count, rows and width;
- byte-masked writes;
- an optional output pipeline register with a read-valid strobe;
- collision flagging;
- a post-reset clear sequencer that zeroes the whole array before accepting traffic.

It sits between the cache/tag controllers and the ASAP7 6T macros as the behavioural model and wrapper for a multi-bank array.

---
 rtl/srambank_param_if.sv | 32 +++
 rtl/srambank_param.sv | 124 ++++++++++++
 2 files changed

// File: rtl/srambank_param_if.sv
// rtl/srambank_param_if.sv - request/response bundle for srambank_param
interface srambank_param_if #(
    parameter int NBANKS = 4,
    parameter int ROWS   = 64,
    parameter int WIDTH  = 72
);
    localparam int BW = $clog2(NBANKS);
    localparam int RW = $clog2(ROWS);
    localparam int AW = BW + RW;
    localparam int MW = WIDTH / 8;

    logic [AW-1:0]    ADDRESS;
    logic [WIDTH-1:0] wd;
    logic [MW-1:0]    wmask;
    logic             banksel;
    logic             read;
    logic             write;
    logic [WIDTH-1:0] dataout;
    logic             dvalid;
    logic             ready;
    logic             collision;

    modport master (
        output ADDRESS, wd, wmask, banksel, read, write,
        input  dataout, dvalid, ready, collision
    );

    modport slave (
        input  ADDRESS, wd, wmask, banksel, read, write,
        output dataout, dvalid, ready, collision
    );
endinterface

// File: rtl/srambank_param.sv
// rtl/srambank_param.sv - multi-bank SRAM model with byte masks, optional output stage and clear sequencer
module srambank_param #(
    parameter int NBANKS = 4,
    parameter int ROWS   = 64,
    parameter int WIDTH  = 72,
    parameter int OUTREG = 1
) (
    input  logic             clk,
    input  logic             reset,
    srambank_param_if.slave  bus
);
    localparam int BW  = (NBANKS > 1) ? $clog2(NBANKS) : 0;
    localparam int RW  = $clog2(ROWS);
    localparam int BIW = (BW > 0) ? BW : 1;
    localparam int MW  = WIDTH / 8;

    typedef enum logic {CLEAR, RUN} state_e;

    state_e             state_q, state_d;
    logic [RW-1:0]      cnt_q, cnt_d;
    logic               s1_vld_q, s1_vld_d;
    logic [BIW-1:0]     s1_bank_q, s1_bank_d;
    logic [WIDTH-1:0]   bank_rd_q [NBANKS];
    logic [WIDTH-1:0]   bank_rd_d [NBANKS];
    logic [WIDTH-1:0]   dataout_q, dataout_d;
    logic               dvalid_q, dvalid_d;
    logic               collision_q, collision_d;

    logic [WIDTH-1:0]   mem [NBANKS][ROWS];
    logic [BIW-1:0]     bank;
    logic [RW-1:0]      row;
    logic               run, do_wr, do_rd;

    generate
        if (NBANKS > 1) begin : g_bank
            assign bank = bus.ADDRESS[BW+RW-1:RW];
        end else begin : g_nobank
            assign bank = '0;
        end
    endgenerate

    assign row   = bus.ADDRESS[RW-1:0];
    assign run   = (state_q == RUN);
    assign do_wr = run & bus.banksel & bus.write;
    assign do_rd = run & bus.banksel & bus.read & ~bus.write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + RW'(1);
            if (cnt_q == RW'(ROWS - 1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end
    end

    // The clear sweeps one row index across every bank per cycle.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            for (int b = 0; b < NBANKS; b++) begin
                mem[b][cnt_q] <= '0;
            end
        end else if (do_wr) begin
            for (int i = 0; i < MW; i++) begin
                if (bus.wmask[i]) begin
                    mem[bank][row][8*i +: 8] <= bus.wd[8*i +: 8];
                end
            end
        end
    end

    // With OUTREG the bank index rides alongside the per-bank read latch to steer the output mux.
    always_comb begin
        s1_vld_d    = do_rd;
        s1_bank_d   = bank;
        bank_rd_d   = bank_rd_q;
        if (do_rd) begin
            bank_rd_d[bank] = mem[bank][row];
        end
        dataout_d   = dataout_q;
        dvalid_d    = 1'b0;
        collision_d = run & bus.banksel & bus.read & bus.write;
        if (OUTREG != 0) begin
            if (s1_vld_q) begin
                dataout_d = bank_rd_q[s1_bank_q];
                dvalid_d  = 1'b1;
            end
        end else if (do_rd) begin
            dataout_d = mem[bank][row];
            dvalid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        bank_rd_q <= bank_rd_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_bank_q   <= '0;
            dataout_q   <= '0;
            dvalid_q    <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s1_vld_q    <= s1_vld_d;
            s1_bank_q   <= s1_bank_d;
            dataout_q   <= dataout_d;
            dvalid_q    <= dvalid_d;
            collision_q <= collision_d;
        end
    end

    assign bus.dataout   = dataout_q;
    assign bus.dvalid    = dvalid_q;
    assign bus.ready     = run;
    assign bus.collision = collision_q;
endmodule
